// File: rtl/lane_array_mem.sv
// ROWS x COLS word memory with lane-masked writes, lane-sliced registered reads and a self-timed clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining LANE_ARRAY_MEM_BYPASS_EN.
module lane_array_mem #(
  parameter  int WIDTH  = 32,
  parameter  int LANE_W = 8,
  parameter  int ROWS   = 16,
  parameter  int COLS   = 16,
  localparam int LANES  = WIDTH / LANE_W,
  localparam int RW     = (ROWS  > 1) ? $clog2(ROWS)  : 1,
  localparam int CW     = (COLS  > 1) ? $clog2(COLS)  : 1,
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [RW-1:0]     wr_row,
  input  logic [CW-1:0]     wr_col,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [LANES-1:0]  wr_mask,
  input  logic              rd_req,
  input  logic [RW-1:0]     rd_row,
  input  logic [CW-1:0]     rd_col,
  input  logic [LW-1:0]     rd_lane,
  input  logic              rd_neg,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [LANE_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int             SRC_W    = WIDTH + LANE_W - 1;
  localparam logic [RW:0]    ROWS_L   = (RW+1)'(ROWS);
  localparam logic [CW:0]    COLS_L   = (CW+1)'(COLS);
  localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0]  COL_LAST = CW'(COLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t          r_state, w_state_next;
  logic [RW-1:0]   r_clr_row, w_clr_row_next;
  logic [CW-1:0]   r_clr_col, w_clr_col_next;
  logic            w_clr_busy, w_clr_done;

  logic [WIDTH-1:0] r_mem [ROWS][COLS];

  logic             w_wr_acc, w_wr_inrange;
  logic             w_rd_acc, w_rd_inrange;
  logic             w_mem_we;
  logic [RW-1:0]    w_mem_row;
  logic [CW-1:0]    w_mem_col;
  logic [WIDTH-1:0] w_mem_data;
  logic [LANES-1:0] w_mem_mask;
  logic [WIDTH-1:0] w_rd_word;
  logic [SRC_W-1:0] w_src, w_shifted;
  logic [31:0]      w_shamt;

  logic              r_rd_valid;
  logic [LANE_W-1:0] r_rd_data;
  logic              r_rd_err;

  // ---------------- clear FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_clr_row <= '0;
      r_clr_col <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_row <= w_clr_row_next;
      r_clr_col <= w_clr_col_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_clr_row_next = r_clr_row;
    w_clr_col_next = r_clr_col;
    w_clr_busy     = 1'b0;
    w_clr_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clr_start) begin
          w_state_next   = S_CLEAR;
          w_clr_row_next = '0;
          w_clr_col_next = '0;
        end
      end
      S_CLEAR: begin
        w_clr_busy = 1'b1;
        // Column is the inner loop; both counters wrap at the programmed size.
        if (r_clr_col == COL_LAST) begin
          w_clr_col_next = '0;
          if (r_clr_row == ROW_LAST) begin
            w_state_next = S_DONE;
          end else begin
            w_clr_row_next = r_clr_row + 1'b1;
          end
        end else begin
          w_clr_col_next = r_clr_col + 1'b1;
        end
      end
      S_DONE: begin
        w_clr_done   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign clr_busy = w_clr_busy;
  assign clr_done = w_clr_done;
  assign rd_ready = !w_clr_busy;

  // ---------------- write port ----------------
  assign w_wr_acc     = wr_en && rd_ready;
  assign w_wr_inrange = ({1'b0, wr_row} < ROWS_L) && ({1'b0, wr_col} < COLS_L);

  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_row  = wr_row;
    w_mem_col  = wr_col;
    w_mem_data = wr_data;
    w_mem_mask = wr_mask;
    if (r_state == S_CLEAR) begin
      w_mem_we   = 1'b1;
      w_mem_row  = r_clr_row;
      w_mem_col  = r_clr_col;
      w_mem_data = '0;
      w_mem_mask = '1;
    end else if (w_wr_acc && w_wr_inrange) begin
      w_mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (w_mem_mask[l]) begin
          r_mem[w_mem_row][w_mem_col][l*LANE_W +: LANE_W] <= w_mem_data[l*LANE_W +: LANE_W];
        end
      end
    end
  end

  // ---------------- read port ----------------
  assign w_rd_acc     = rd_req && rd_ready;
  assign w_rd_inrange = ({1'b0, rd_row} < ROWS_L) && ({1'b0, rd_col} < COLS_L);

  always_comb begin
    w_rd_word = '0;
    if (w_rd_inrange) begin
      w_rd_word = r_mem[rd_row][rd_col];
`ifdef LANE_ARRAY_MEM_BYPASS_EN
      if (w_wr_acc && w_wr_inrange && (wr_row == rd_row) && (wr_col == rd_col)) begin
        for (int l = 0; l < LANES; l++) begin
          if (wr_mask[l]) begin
            w_rd_word[l*LANE_W +: LANE_W] = wr_data[l*LANE_W +: LANE_W];
          end
        end
      end
`endif
    end
  end

  // Descending slices shift the word up by LANE_W-1 so positions below bit 0 become zeros.
  assign w_src     = rd_neg ? (SRC_W'(w_rd_word) << (LANE_W - 1)) : SRC_W'(w_rd_word);
  assign w_shamt   = 32'(rd_lane) * LANE_W;
  assign w_shifted = w_src >> w_shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_err   <= 1'b0;
    end else if (w_rd_acc) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= w_rd_inrange ? w_shifted[LANE_W-1:0] : '0;
      r_rd_err   <= !w_rd_inrange;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_err   = r_rd_err;

endmodule

// File: tb/tb_lane_array_mem.sv
// Directed bench for lane_array_mem: a 16x16 instance for most scenarios, a 10-row instance for range checks.
module tb_lane_array_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        wr_en, rd_req, rd_neg, clr_start;
  logic [3:0]  wr_row, wr_col, rd_row, rd_col, wr_mask;
  logic [31:0] wr_data;
  logic [1:0]  rd_lane;
  logic        rd_ready, rd_valid, rd_err, clr_busy, clr_done;
  logic [7:0]  rd_data;

  logic        b_wr_en, b_rd_req, b_rd_neg, b_clr_start;
  logic [3:0]  b_wr_row, b_wr_col, b_rd_row, b_rd_col, b_wr_mask;
  logic [31:0] b_wr_data;
  logic [1:0]  b_rd_lane;
  logic        b_rd_ready, b_rd_valid, b_rd_err, b_clr_busy, b_clr_done;
  logic [7:0]  b_rd_data;

  int checks   = 0;
  int failures = 0;

  lane_array_mem #(.WIDTH(32), .LANE_W(8), .ROWS(16), .COLS(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col), .rd_lane(rd_lane), .rd_neg(rd_neg),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  lane_array_mem #(.WIDTH(32), .LANE_W(8), .ROWS(10), .COLS(16)) u_dut10 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(b_wr_en), .wr_row(b_wr_row), .wr_col(b_wr_col), .wr_data(b_wr_data), .wr_mask(b_wr_mask),
    .rd_req(b_rd_req), .rd_row(b_rd_row), .rd_col(b_rd_col), .rd_lane(b_rd_lane), .rd_neg(b_rd_neg),
    .rd_ready(b_rd_ready), .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_err(b_rd_err),
    .clr_start(b_clr_start), .clr_busy(b_clr_busy), .clr_done(b_clr_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_read(input logic [3:0] r, input logic [3:0] c, input logic [1:0] l, input logic n);
    rd_req = 1'b1; rd_row = r; rd_col = c; rd_lane = l; rd_neg = n;
  endtask

  task automatic set_write(input logic [3:0] r, input logic [3:0] c, input logic [31:0] d, input logic [3:0] m);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_data = d; wr_mask = m;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wr_en = 0; rd_req = 0; rd_neg = 0; clr_start = 0;
    wr_row = 0; wr_col = 0; rd_row = 0; rd_col = 0; wr_mask = 0; wr_data = 0; rd_lane = 0;
    b_wr_en = 0; b_rd_req = 0; b_rd_neg = 0; b_clr_start = 0;
    b_wr_row = 0; b_wr_col = 0; b_rd_row = 0; b_rd_col = 0; b_wr_mask = 0; b_wr_data = 0; b_rd_lane = 0;
    #12;
    $display("reset: valid=%0b data=%02h err=%0b busy=%0b done=%0b ready=%0b",
             rd_valid, rd_data, rd_err, clr_busy, clr_done, rd_ready);
    checks++;
    if ({rd_valid, rd_data, rd_err, clr_busy, clr_done} !== 12'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %03h expected 000", {rd_valid, rd_data, rd_err, clr_busy, clr_done});
    end
    checks++;
    if (rd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %0b expected 1", rd_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_clear;
    int busy_cnt;
    clr_start = 1'b1;
    tick;
    clr_start = 1'b0;
    busy_cnt = 0;
    while (clr_busy === 1'b1 && busy_cnt < 400) begin
      busy_cnt++;
      tick;
    end
    $display("clear: busy cycles=%0d done=%0b", busy_cnt, clr_done);
    checks++;
    if (busy_cnt != 256) begin
      failures++;
      $display("FAIL clear_busy_cycles: got %0d expected 256", busy_cnt);
    end
    checks++;
    if (clr_done !== 1'b1) begin
      failures++;
      $display("FAIL clear_done_pulse: got %0b expected 1", clr_done);
    end
    tick;
    checks++;
    if (clr_done !== 1'b0) begin
      failures++;
      $display("FAIL clear_done_width: got %0b expected 0", clr_done);
    end
    set_read(4'd3, 4'd7, 2'd1, 1'b0);
    tick;
    rd_req = 1'b0;
    $display("read (3,7) lane1 asc -> valid=%0b data=%02h err=%0b", rd_valid, rd_data, rd_err);
    checks++;
    if ({rd_valid, rd_data, rd_err} !== {1'b1, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL clear_read: got v=%0b d=%02h e=%0b expected v=1 d=00 e=0", rd_valid, rd_data, rd_err);
    end
  endtask

  task automatic test_lane_slices;
    logic [7:0] exp_a [7];
    logic [1:0] lane_a [7];
    logic       neg_a [7];
    set_write(4'd1, 4'd12, 32'hDEADBEEF, 4'b1111);
    tick;
    wr_en = 1'b0;
    $display("write (1,12)=deadbeef mask=1111");
    // Back-to-back reads: a new request is presented every cycle.
    lane_a = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    neg_a  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_a  = '{8'hAD, 8'hDF, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) begin
      set_read(4'd1, 4'd12, lane_a[i], neg_a[i]);
      tick;
      $display("read (1,12) lane%0d neg=%0b -> valid=%0b data=%02h", lane_a[i], neg_a[i], rd_valid, rd_data);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_a[i]) begin
        failures++;
        $display("FAIL slice_%0d: got v=%0b d=%02h expected v=1 d=%02h", i, rd_valid, rd_data, exp_a[i]);
      end
    end
    rd_req = 1'b0;
    tick;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h80) begin
      failures++;
      $display("FAIL hold_after_read: got v=%0b d=%02h expected v=0 d=80", rd_valid, rd_data);
    end
    set_write(4'd1, 4'd12, 32'h12345678, 4'b0101);
    tick;
    wr_en = 1'b0;
    $display("write (1,12)=12345678 mask=0101");
    lane_a = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd0, 2'd0};
    neg_a  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_a  = '{8'hDE, 8'h34, 8'hBE, 8'h78, 8'h1A, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) begin
      set_read(4'd1, 4'd12, lane_a[i], neg_a[i]);
      tick;
      $display("read (1,12) lane%0d neg=%0b -> valid=%0b data=%02h", lane_a[i], neg_a[i], rd_valid, rd_data);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_a[i]) begin
        failures++;
        $display("FAIL masked_slice_%0d: got v=%0b d=%02h expected v=1 d=%02h", i, rd_valid, rd_data, exp_a[i]);
      end
    end
    rd_req = 1'b0;
    tick;
  endtask

  task automatic test_out_of_range;
    b_wr_en = 1'b1; b_wr_row = 4'd12; b_wr_col = 4'd0; b_wr_data = 32'hFFFFFFFF; b_wr_mask = 4'hF;
    tick;
    b_wr_row = 4'd9; b_wr_col = 4'd15; b_wr_data = 32'hA5C3_0000;
    tick;
    b_wr_en = 1'b0;
    b_rd_req = 1'b1; b_rd_row = 4'd12; b_rd_col = 4'd0; b_rd_lane = 2'd0; b_rd_neg = 1'b0;
    tick;
    $display("rows10 read (12,0) -> valid=%0b data=%02h err=%0b", b_rd_valid, b_rd_data, b_rd_err);
    checks++;
    if ({b_rd_valid, b_rd_data, b_rd_err} !== {1'b1, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL oor_read: got v=%0b d=%02h e=%0b expected v=1 d=00 e=1", b_rd_valid, b_rd_data, b_rd_err);
    end
    b_rd_row = 4'd9; b_rd_col = 4'd15; b_rd_lane = 2'd3;
    tick;
    b_rd_req = 1'b0;
    $display("rows10 read (9,15) lane3 -> valid=%0b data=%02h err=%0b", b_rd_valid, b_rd_data, b_rd_err);
    checks++;
    if ({b_rd_valid, b_rd_data, b_rd_err} !== {1'b1, 8'hA5, 1'b0}) begin
      failures++;
      $display("FAIL last_row_read: got v=%0b d=%02h e=%0b expected v=1 d=a5 e=0", b_rd_valid, b_rd_data, b_rd_err);
    end
    tick;
  endtask

  task automatic test_bypass;
    logic [7:0] exp_same;
`ifdef LANE_ARRAY_MEM_BYPASS_EN
    exp_same = 8'hAA;
`else
    exp_same = 8'h00;
`endif
    set_write(4'd2, 4'd2, 32'h000000AA, 4'hF);
    set_read(4'd2, 4'd2, 2'd0, 1'b0);
    tick;
    wr_en = 1'b0;
    $display("same-cycle write/read (2,2) lane0 -> data=%02h", rd_data);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_same) begin
      failures++;
      $display("FAIL same_cycle_read: got v=%0b d=%02h expected v=1 d=%02h", rd_valid, rd_data, exp_same);
    end
    tick;
    rd_req = 1'b0;
    $display("read (2,2) lane0 -> data=%02h", rd_data);
    checks++;
    if (rd_data !== 8'hAA) begin
      failures++;
      $display("FAIL after_write_read: got %02h expected aa", rd_data);
    end
    tick;
  endtask

  task automatic test_reset_mid_clear;
    int busy_cnt, done_cnt;
    clr_start = 1'b1;
    tick;
    clr_start = 1'b0;
    set_read(4'd2, 4'd2, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) tick;
    $display("mid-clear request: ready=%0b valid=%0b", rd_ready, rd_valid);
    checks++;
    if (rd_ready !== 1'b0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL blocked_read: got ready=%0b v=%0b expected ready=0 v=0", rd_ready, rd_valid);
    end
    rd_req = 1'b0;
    rst_n = 1'b0;
    #1;
    $display("reset mid-clear: valid=%0b data=%02h err=%0b busy=%0b done=%0b",
             rd_valid, rd_data, rd_err, clr_busy, clr_done);
    checks++;
    if ({rd_valid, rd_data, rd_err, clr_busy, clr_done} !== 12'h0) begin
      failures++;
      $display("FAIL mid_clear_reset: got %03h expected 000", {rd_valid, rd_data, rd_err, clr_busy, clr_done});
    end
    #2;
    rst_n = 1'b1;
    set_read(4'd2, 4'd2, 2'd0, 1'b0);
    tick;
    rd_req = 1'b0;
    $display("read after reset (2,2) -> valid=%0b data=%02h", rd_valid, rd_data);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hAA) begin
      failures++;
      $display("FAIL read_after_reset: got v=%0b d=%02h expected v=1 d=aa", rd_valid, rd_data);
    end
    clr_start = 1'b1;
    tick;
    clr_start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (clr_busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) begin
        done_cnt++;
        clr_start = 1'b1;
      end
      if (i == 50) clr_start = 1'b1;
      tick;
      clr_start = 1'b0;
    end
    $display("clear with extra starts: busy cycles=%0d done pulses=%0d", busy_cnt, done_cnt);
    checks++;
    if (busy_cnt != 256) begin
      failures++;
      $display("FAIL restart_busy_cycles: got %0d expected 256", busy_cnt);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL restart_done_count: got %0d expected 1", done_cnt);
    end
    set_read(4'd2, 4'd2, 2'd0, 1'b0);
    tick;
    rd_req = 1'b0;
    $display("read (2,2) after full clear -> valid=%0b data=%02h", rd_valid, rd_data);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
      failures++;
      $display("FAIL cleared_read: got v=%0b d=%02h expected v=1 d=00", rd_valid, rd_data);
    end
  endtask

  initial begin
    test_reset;
    test_clear;
    test_lane_slices;
    test_out_of_range;
    test_bypass;
    test_reset_mid_clear;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
